// File: rtl/range_gate_pulser_pkg.sv
// Shared definitions for the range-gate timing blocks: state encoding,
// default field widths and small elaboration-time helpers.
package range_gate_pulser_pkg;

  localparam int DELAY_W_DEF = 16;
  localparam int WIDTH_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_DELAY  = 2'd2,
    ST_ACTIVE = 2'd3
  } gate_state_e;

  // Number of bits needed to hold values 0..value-1.
  function automatic int clogb2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  function automatic int max_of(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/range_gate_pulser_edge.sv
// Rising-edge detector for a level sampled in the IN_CLK domain. The history
// flop resets to RESET_VAL so a level held through reset yields no edge.
module rise_edge_det
  import range_gate_pulser_pkg::*;
#(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic IN_CLK,
  input  logic RST,
  input  logic D,
  output logic EDGE
);

  logic d_q;

  // History of the sampled level.
  always_ff @(posedge IN_CLK) begin
    if (RST) begin
      d_q <= RESET_VAL;
    end else begin
      d_q <= D;
    end
  end

  assign EDGE = D & ~d_q;

endmodule

// File: rtl/range_gate_pulser.sv
// One video pulse per radar trigger: waits a programmed number of range ticks,
// then holds PULSE for a programmed number of ticks.
module range_gate_pulser
  import range_gate_pulser_pkg::*;
#(
  parameter int DELAY_W = DELAY_W_DEF,
  parameter int WIDTH_W = WIDTH_W_DEF
) (
  input  logic               IN_CLK,
  input  logic               RST,
  input  logic               DIV_CLK,
  input  logic               TRIG,
  input  logic [DELAY_W-1:0] CFG_DELAY,
  input  logic [WIDTH_W-1:0] CFG_WIDTH,
  input  logic               CFG_VALID,
  output logic               CFG_READY,
  output logic               PULSE,
  output logic               DONE,
  output logic               MISSED
);

  localparam int CNT_W = max_of(DELAY_W, WIDTH_W);
  localparam logic [CNT_W-1:0]   CNT_ZERO = '0;
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1'b1);
  localparam logic [WIDTH_W-1:0] WID_ZERO = '0;

  gate_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic               pulse_q, pulse_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               missed_q, missed_d;

  logic               tick_s;
  logic               trig_edge_s;
  logic               sweep_end_s;
  logic [CNT_W-1:0]   width_ext_s;

  rise_edge_det #(.RESET_VAL(1'b1)) u_tick_det (
    .IN_CLK (IN_CLK),
    .RST    (RST),
    .D      (DIV_CLK),
    .EDGE   (tick_s)
  );

  rise_edge_det #(.RESET_VAL(1'b1)) u_trig_det (
    .IN_CLK (IN_CLK),
    .RST    (RST),
    .D      (TRIG),
    .EDGE   (trig_edge_s)
  );

  assign width_ext_s = CNT_W'(width_q);

  // State, counter, latched width and registered outputs.
  always_ff @(posedge IN_CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      width_q  <= WID_ZERO;
      pulse_q  <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      width_q  <= width_d;
      pulse_q  <= pulse_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      missed_q <= missed_d;
    end
  end

  // Next-state and counter update; transitions fire when the counter is 1,
  // so the unsigned counter never underflows.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    width_d     = width_q;
    sweep_end_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CFG_VALID && ready_q) begin
          width_d = CFG_WIDTH;
          cnt_d   = CNT_W'(CFG_DELAY);
          state_d = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        // A tick coinciding with the trigger edge is deliberately ignored.
        if (trig_edge_s) begin
          if ((cnt_q == CNT_ZERO) && (width_q == WID_ZERO)) begin
            state_d     = ST_IDLE;
            sweep_end_s = 1'b1;
          end else if (cnt_q == CNT_ZERO) begin
            state_d = ST_ACTIVE;
            cnt_d   = width_ext_s;
          end else begin
            state_d = ST_DELAY;
          end
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_DELAY: begin
        if (tick_s) begin
          cnt_d = cnt_q - CNT_ONE;
          if ((cnt_q == CNT_ONE) && (width_q == WID_ZERO)) begin
            state_d     = ST_IDLE;
            sweep_end_s = 1'b1;
          end else if (cnt_q == CNT_ONE) begin
            state_d = ST_ACTIVE;
            cnt_d   = width_ext_s;
          end else begin
            state_d = ST_DELAY;
          end
        end else begin
          state_d = ST_DELAY;
        end
      end
      ST_ACTIVE: begin
        if (tick_s) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d     = ST_IDLE;
            sweep_end_s = 1'b1;
          end else begin
            state_d = ST_ACTIVE;
          end
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    pulse_d  = (state_d == ST_ACTIVE);
    ready_d  = (state_d == ST_IDLE);
    done_d   = sweep_end_s;
    missed_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_DELAY, ST_ACTIVE: missed_d = trig_edge_s;
      default:                      missed_d = 1'b0;
    endcase
  end

  assign CFG_READY = ready_q;
  assign PULSE     = pulse_q;
  assign DONE      = done_q;
  assign MISSED    = missed_q;

endmodule
